dot_field: RTL and testbench
============================

// Module: dot_field
// PURPOSE
//  Parametrised pellet field for the maze game: owns N_DOTS dot positions, per-dot alive state, eat detection
//  against the player sprite once per frame, optional per-dot respawn, score accumulation and level-clear/refill.
//  Feeds the colour mapper (is_dots, dot_number) and the score display; sits beside the player/ghost motion blocks.
// PARAMETERS
//  N_DOTS         16    number of dots (2..64)
//  DOT_HALF       2     dot half-extent in pixels; dot covers PosX+-DOT_HALF, PosY+-DOT_HALF
//  POINTS         10    score added per dot eaten
//  SCORE_W        16    score width, saturating
//  RESPAWN_EN     0     1: an eaten dot reappears RESPAWN_FRAMES frames after being eaten
//  RESPAWN_FRAMES 600   frames an eaten dot stays dead (RESPAWN_EN=1 only)
//  CLEAR_FRAMES   120   frames between level_clear and automatic refill
// PORTS
//  Clk          in   1               system clock
//  Reset        in   1               synchronous, active-high
//  frame_clk    in   1               vertical sync; rising edge = one frame tick
//  DotX_flat    in   10*N_DOTS       dot i X centre at [10*i +: 10]
//  DotY_flat    in   10*N_DOTS       dot i Y centre at [10*i +: 10]
//  PlayerX      in   10              player centre X
//  PlayerY      in   10              player centre Y
//  PlayerSize   in   10              player half-extent
//  kill         in   N_DOTS          external clear of dot i; no score
//  DrawX,DrawY  in   10 each         current VGA pixel
//  alive        out  N_DOTS          registered per-dot alive flags
//  is_dot       out  N_DOTS          pixel inside dot i AND alive[i]
//  is_dots      out  1               |is_dot
//  dot_number   out  $clog2(N_DOTS)  lowest index set in is_dot; 0 when none
//  score        out  SCORE_W         accumulated score
//  eat_pulse    out  1               1-cycle pulse on a tick that ate >=1 dot
//  level_clear  out  1               1-cycle pulse when the last alive dot dies
// BEHAVIOUR
//  - Reset: alive all 1, score 0, all respawn timers 0, eat_pulse 0, level_clear 0, state PLAY.
//    Reset mid-CLEAR_WAIT aborts the wait; the field is full the cycle after Reset deasserts.
//  - tick: frame_clk sampled into one register; tick = frame_clk & ~frame_clk_q. Exactly 1 Clk wide.
//  - Collision on tick, dot i: alive[i] and |PlayerX-DotX_i| <= PlayerSize+DOT_HALF and same in Y.
//    Use 11-bit unsigned abs difference; no wrap.
//  - All colliding dots clear in the same cycle. score += POINTS*popcount(eaten). Saturate at 2^SCORE_W-1.
//    eat_pulse is asserted in that same cycle (registered; visible the cycle after the tick).
//  - kill[i] clears alive[i] on any cycle, including non-tick cycles. No score, no eat_pulse.
//  - Respawn (RESPAWN_EN=1): eating or killing dot i loads timer_i = RESPAWN_FRAMES.
//    Each tick decrements non-zero timers; the tick reaching 0 sets alive[i].
//    kill[i] in the same cycle as expiry: kill wins and the timer reloads.
//  - Respawn with RESPAWN_EN=0: timers are absent and dots stay dead until refill.
//  - FSM PLAY: the cycle alive transitions to all zero (from any cause) -> pulse level_clear and go to CLEAR_WAIT.
//    CLEAR_WAIT loads wait_cnt = CLEAR_FRAMES. Eat detection and respawn are frozen; kill is still honoured.
//  - FSM CLEAR_WAIT: wait_cnt decrements per tick. On the tick reaching 0, alive is set to all 1,
//    timers are cleared, and the FSM returns to PLAY. Score is retained.
//  - Render path is combinational from DrawX/DrawY and the registered alive.
//    Pixel is in dot i when |DrawX-DotX_i|<=DOT_HALF and |DrawY-DotY_i|<=DOT_HALF.
// TESTING
//  1 Reset, N_DOTS=4, dots at (100,100),(200,100),(300,100),(400,100) -> alive=4'hF, score=0;
//    DrawX/Y=(201,99) -> is_dots=1, dot_number=1.
//  2 Player (100,100), size 8, one tick -> alive=4'hE, score=10, eat_pulse for 1 cycle; next tick -> score stays 10.
//  3 Dots 0,1 at (100,100),(104,100), player (102,100) -> both cleared on one tick, score=20.
//    Overlapping pixel (102,100) -> dot_number=0.
//  4 RESPAWN_EN=1, RESPAWN_FRAMES=3: eat dot 2 -> alive[2]=0 for 2 ticks, 1 after the 3rd tick.
//    kill[2] asserted on the expiry cycle -> stays 0.
//  5 Kill dots 0..2, eat dot 3 -> level_clear 1 cycle, score=10; CLEAR_FRAMES=2 -> alive=4'hF after 2 ticks.
//    Player on dot 0 during the wait -> no score.
//  6 SCORE_W=5, POINTS=10, eat 4 dots on separate ticks -> score 10,20,30,31 (saturated).
//    Reset during CLEAR_WAIT -> alive=4'hF, score=0.

Source files
------------

// File: rtl/dot_field.sv
// Pellet field for the maze game: dot storage, eat detection on frame ticks,
// optional per-dot respawn, saturating score and level-clear / refill sequencing.
module dot_field #(
    parameter int N_DOTS         = 16,
    parameter int DOT_HALF       = 2,
    parameter int POINTS         = 10,
    parameter int SCORE_W        = 16,
    parameter int RESPAWN_EN     = 0,
    parameter int RESPAWN_FRAMES = 600,
    parameter int CLEAR_FRAMES   = 120
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic [10*N_DOTS-1:0]      DotX_flat,
    input  logic [10*N_DOTS-1:0]      DotY_flat,
    input  logic [9:0]                PlayerX,
    input  logic [9:0]                PlayerY,
    input  logic [9:0]                PlayerSize,
    input  logic [N_DOTS-1:0]         kill,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    output logic [N_DOTS-1:0]         alive,
    output logic [N_DOTS-1:0]         is_dot,
    output logic                      is_dots,
    output logic [$clog2(N_DOTS)-1:0] dot_number,
    output logic [SCORE_W-1:0]        score,
    output logic                      eat_pulse,
    output logic                      level_clear
);

    localparam int NUM_W  = $clog2(N_DOTS);
    localparam int CNT_W  = $clog2(N_DOTS + 1);
    localparam int TMR_W  = (RESPAWN_FRAMES < 1) ? 1 : $clog2(RESPAWN_FRAMES + 1);
    localparam int WAIT_W = (CLEAR_FRAMES < 1) ? 1 : $clog2(CLEAR_FRAMES + 1);
    localparam int SUM_W  = SCORE_W + 32 + CNT_W;

    typedef enum logic {PLAY, CLEAR_WAIT} state_t;

    state_t              state_q, state_d;
    logic                frame_clk_q;
    logic                tick;
    logic [N_DOTS-1:0]   alive_q, alive_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [TMR_W-1:0]    timer_q [N_DOTS];
    logic [TMR_W-1:0]    timer_d [N_DOTS];
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                eat_q, eat_d;
    logic                lc_q, lc_d;
    logic [N_DOTS-1:0]   hit;
    logic [N_DOTS-1:0]   eaten;
    logic [CNT_W-1:0]    eat_cnt;
    logic [10:0]         reach;

    // 11-bit magnitude of a difference between two 10-bit coordinates; never wraps
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        if (a >= b) return {1'b0, a - b};
        else        return {1'b0, b - a};
    endfunction

    // Add n dots' worth of points and clamp at the all-ones score
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                  input logic [CNT_W-1:0]   n);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + SUM_W'(POINTS) * SUM_W'(n);
        if (sum > SUM_W'({SCORE_W{1'b1}})) return {SCORE_W{1'b1}};
        else                               return sum[SCORE_W-1:0];
    endfunction

    assign tick  = frame_clk & ~frame_clk_q;
    assign reach = {1'b0, PlayerSize} + 11'(DOT_HALF);

    // Player/dot bounding-box overlap for every dot, independent of alive state
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_DOTS; i++) begin
            hit[i] = (abs_diff(PlayerX, DotX_flat[10*i +: 10]) <= reach) &&
                     (abs_diff(PlayerY, DotY_flat[10*i +: 10]) <= reach);
        end
    end

    // Eating only happens on a frame tick while playing; frozen during the clear wait
    assign eaten = (state_q == PLAY && tick) ? (alive_q & hit) : '0;

    // Number of dots eaten this cycle
    always_comb begin
        eat_cnt = '0;
        for (int i = 0; i < N_DOTS; i++) begin
            eat_cnt = eat_cnt + CNT_W'(eaten[i]);
        end
    end

    // Field, score, respawn timers and play/clear-wait sequencing
    always_comb begin
        alive_d = alive_q;
        score_d = score_q;
        timer_d = timer_q;
        wait_d  = wait_q;
        state_d = state_q;
        eat_d   = 1'b0;
        lc_d    = 1'b0;
        case (state_q)
            PLAY: begin
                if (tick) begin
                    for (int i = 0; i < N_DOTS; i++) begin
                        if (eaten[i]) begin
                            alive_d[i] = 1'b0;
                            if (RESPAWN_EN != 0) timer_d[i] = TMR_W'(RESPAWN_FRAMES);
                        end else if (RESPAWN_EN != 0 && timer_q[i] != '0) begin
                            timer_d[i] = timer_q[i] - TMR_W'(1);
                            if (timer_q[i] == TMR_W'(1)) alive_d[i] = 1'b1;
                        end
                    end
                    score_d = sat_add(score_q, eat_cnt);
                    eat_d   = |eaten;
                end
            end
            CLEAR_WAIT: begin
                if (tick) begin
                    if (wait_q <= WAIT_W'(1)) begin
                        alive_d = '1;
                        for (int i = 0; i < N_DOTS; i++) timer_d[i] = '0;
                        state_d = PLAY;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
            end
            default: state_d = PLAY;
        endcase
        // An external kill overrides everything else for that dot, including an expiring timer
        for (int i = 0; i < N_DOTS; i++) begin
            if (kill[i]) begin
                alive_d[i] = 1'b0;
                if (RESPAWN_EN != 0) timer_d[i] = TMR_W'(RESPAWN_FRAMES);
            end
        end
        if (state_q == PLAY && (|alive_q) && !(|alive_d)) begin
            lc_d    = 1'b1;
            state_d = CLEAR_WAIT;
            wait_d  = WAIT_W'(CLEAR_FRAMES);
        end
    end

    // State registers with synchronous reset to a full field and zero score
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_q <= 1'b0;
            state_q     <= PLAY;
            alive_q     <= '1;
            score_q     <= '0;
            wait_q      <= '0;
            eat_q       <= 1'b0;
            lc_q        <= 1'b0;
            for (int i = 0; i < N_DOTS; i++) timer_q[i] <= '0;
        end else begin
            frame_clk_q <= frame_clk;
            state_q     <= state_d;
            alive_q     <= alive_d;
            score_q     <= score_d;
            wait_q      <= wait_d;
            eat_q       <= eat_d;
            lc_q        <= lc_d;
            for (int i = 0; i < N_DOTS; i++) timer_q[i] <= timer_d[i];
        end
    end

    // Pixel hit test against live dots; lowest index wins where dots overlap
    always_comb begin
        is_dot     = '0;
        dot_number = '0;
        for (int i = 0; i < N_DOTS; i++) begin
            is_dot[i] = alive_q[i] &&
                        (abs_diff(DrawX, DotX_flat[10*i +: 10]) <= 11'(DOT_HALF)) &&
                        (abs_diff(DrawY, DotY_flat[10*i +: 10]) <= 11'(DOT_HALF));
        end
        for (int i = N_DOTS - 1; i >= 0; i--) begin
            if (is_dot[i]) dot_number = NUM_W'(i);
        end
    end

    assign is_dots     = |is_dot;
    assign alive       = alive_q;
    assign score       = score_q;
    assign eat_pulse   = eat_q;
    assign level_clear = lc_q;

endmodule

// File: tb/tb_dot_field.sv
// Bench for dot_field: two instances (no-respawn / respawn with 5-bit score) share stimulus
// and are compared every cycle against an integer reference model of the field.
module tb_dot_field;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [39:0] DotX_flat, DotY_flat;
    logic [9:0]  PlayerX, PlayerY, PlayerSize;
    logic [3:0]  kill;
    logic [9:0]  DrawX, DrawY;

    logic [3:0]  a_alive, a_is_dot, b_alive, b_is_dot;
    logic        a_is_dots, b_is_dots, a_eat, b_eat, a_lc, b_lc;
    logic [1:0]  a_num, b_num;
    logic [15:0] a_score;
    logic [4:0]  b_score;

    int total = 0;
    int bad   = 0;

    dot_field #(.N_DOTS(4), .DOT_HALF(2), .POINTS(10), .SCORE_W(16), .RESPAWN_EN(0),
                .RESPAWN_FRAMES(3), .CLEAR_FRAMES(2)) u_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DotX_flat(DotX_flat), .DotY_flat(DotY_flat),
        .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerSize(PlayerSize), .kill(kill),
        .DrawX(DrawX), .DrawY(DrawY), .alive(a_alive), .is_dot(a_is_dot), .is_dots(a_is_dots),
        .dot_number(a_num), .score(a_score), .eat_pulse(a_eat), .level_clear(a_lc));

    dot_field #(.N_DOTS(4), .DOT_HALF(2), .POINTS(10), .SCORE_W(5), .RESPAWN_EN(1),
                .RESPAWN_FRAMES(3), .CLEAR_FRAMES(2)) u_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DotX_flat(DotX_flat), .DotY_flat(DotY_flat),
        .PlayerX(PlayerX), .PlayerY(PlayerY), .PlayerSize(PlayerSize), .kill(kill),
        .DrawX(DrawX), .DrawY(DrawY), .alive(b_alive), .is_dot(b_is_dot), .is_dots(b_is_dots),
        .dot_number(b_num), .score(b_score), .eat_pulse(b_eat), .level_clear(b_lc));

    always #5 Clk = ~Clk;

    // Reference model state, index 0 = instance a, 1 = instance b
    localparam int P_RESP[2] = '{0, 1};
    localparam int P_MAX[2]  = '{65535, 31};
    bit m_alive[2][4];
    int m_tmr[2][4];
    int m_score[2];
    bit m_inwait[2];
    int m_wait[2];
    bit m_eat[2], m_lc[2], m_fq[2];

    function automatic int dotx(int i); return int'(DotX_flat[10*i +: 10]); endfunction
    function automatic int doty(int i); return int'(DotY_flat[10*i +: 10]); endfunction
    function automatic int iabs(int v); return (v < 0) ? -v : v; endfunction
    function automatic int clamp10(int v); return (v < 0) ? 0 : ((v > 1023) ? 1023 : v); endfunction

    function automatic bit m_hit(int i);
        int r;
        r = int'(PlayerSize) + 2;
        return (iabs(int'(PlayerX) - dotx(i)) <= r) && (iabs(int'(PlayerY) - doty(i)) <= r);
    endfunction

    function automatic int m_isdot(int k);
        int bits;
        bits = 0;
        for (int i = 0; i < 4; i++)
            if (m_alive[k][i] && iabs(int'(DrawX) - dotx(i)) <= 2 && iabs(int'(DrawY) - doty(i)) <= 2)
                bits |= (1 << i);
        return bits;
    endfunction

    function automatic int m_num(int k);
        int bits;
        bits = m_isdot(k);
        for (int i = 0; i < 4; i++) if (bits[i]) return i;
        return 0;
    endfunction

    function automatic int m_alive_int(int k);
        int v;
        v = 0;
        for (int i = 0; i < 4; i++) if (m_alive[k][i]) v |= (1 << i);
        return v;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit tck;
            int n;
            bit was_play, any_before;
            tck = frame_clk && !m_fq[k];
            if (Reset) begin
                for (int i = 0; i < 4; i++) begin m_alive[k][i] = 1; m_tmr[k][i] = 0; end
                m_score[k] = 0; m_inwait[k] = 0; m_wait[k] = 0;
                m_eat[k] = 0; m_lc[k] = 0; m_fq[k] = 0;
            end else begin
                m_fq[k]    = frame_clk;
                was_play   = !m_inwait[k];
                any_before = (m_alive_int(k) != 0);
                m_eat[k]   = 0;
                m_lc[k]    = 0;
                n          = 0;
                if (was_play && tck) begin
                    bit ate[4];
                    for (int i = 0; i < 4; i++) ate[i] = m_alive[k][i] && m_hit(i);
                    for (int i = 0; i < 4; i++) begin
                        if (ate[i]) begin
                            m_alive[k][i] = 0; n++;
                            if (P_RESP[k] != 0) m_tmr[k][i] = 3;
                        end else if (P_RESP[k] != 0 && m_tmr[k][i] > 0) begin
                            m_tmr[k][i]--;
                            if (m_tmr[k][i] == 0) m_alive[k][i] = 1;
                        end
                    end
                    m_score[k] = m_score[k] + 10 * n;
                    if (m_score[k] > P_MAX[k]) m_score[k] = P_MAX[k];
                    m_eat[k] = (n > 0);
                end else if (!was_play && tck) begin
                    m_wait[k]--;
                    if (m_wait[k] <= 0) begin
                        for (int i = 0; i < 4; i++) begin m_alive[k][i] = 1; m_tmr[k][i] = 0; end
                        m_inwait[k] = 0;
                    end
                end
                for (int i = 0; i < 4; i++)
                    if (kill[i]) begin
                        m_alive[k][i] = 0;
                        if (P_RESP[k] != 0) m_tmr[k][i] = 3;
                    end
                if (was_play && any_before && m_alive_int(k) == 0) begin
                    m_lc[k] = 1; m_inwait[k] = 1; m_wait[k] = 2;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("m_alive_a", int'(a_alive), m_alive_int(0));
        chk("m_score_a", int'(a_score), m_score[0]);
        chk("m_eat_a",   int'(a_eat),   int'(m_eat[0]));
        chk("m_lc_a",    int'(a_lc),    int'(m_lc[0]));
        chk("m_isdot_a", int'(a_is_dot), m_isdot(0));
        chk("m_isdots_a", int'(a_is_dots), int'(m_isdot(0) != 0));
        chk("m_num_a",   int'(a_num),   m_num(0));
        chk("m_alive_b", int'(b_alive), m_alive_int(1));
        chk("m_score_b", int'(b_score), m_score[1]);
        chk("m_eat_b",   int'(b_eat),   int'(m_eat[1]));
        chk("m_lc_b",    int'(b_lc),    int'(m_lc[1]));
        chk("m_isdot_b", int'(b_is_dot), m_isdot(1));
        chk("m_num_b",   int'(b_num),   m_num(1));
    endtask

    task automatic cycle();
        @(posedge Clk);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic tick_edge();
        frame_clk = 1'b1;
        cycle();
        frame_clk = 1'b0;
    endtask

    task automatic set_dot(input int i, input int x, input int y);
        DotX_flat[10*i +: 10] = 10'(x);
        DotY_flat[10*i +: 10] = 10'(y);
    endtask

    task automatic set_player(input int x, input int y, input int s);
        PlayerX = 10'(x); PlayerY = 10'(y); PlayerSize = 10'(s);
    endtask

    task automatic do_reset();
        Reset = 1'b1; cycle(); Reset = 1'b0; cycle();
    endtask

    task automatic default_layout();
        for (int i = 0; i < 4; i++) set_dot(i, 100 + 100 * i, 100);
    endtask

    typedef struct { int x; int y; int dots; int num; int bits; } rvec_t;

    initial begin
        rvec_t rt[8];
        rt[0] = '{201,  99, 1, 1, 2};
        rt[1] = '{100, 100, 1, 0, 1};
        rt[2] = '{102, 102, 1, 0, 1};
        rt[3] = '{103, 100, 0, 0, 0};
        rt[4] = '{398,  98, 1, 3, 8};
        rt[5] = '{250, 100, 0, 0, 0};
        rt[6] = '{300,  97, 0, 0, 0};
        rt[7] = '{302,  98, 1, 2, 4};

        Reset = 1'b1; frame_clk = 1'b0; kill = '0;
        DotX_flat = '0; DotY_flat = '0;
        default_layout();
        set_player(700, 400, 8);
        DrawX = '0; DrawY = '0;

        // 1: reset state and render table
        cycle(); cycle();
        Reset = 1'b0;
        cycle();
        chk("rst_alive_a", int'(a_alive), 15);
        chk("rst_score_a", int'(a_score), 0);
        chk("rst_eat_a",   int'(a_eat), 0);
        chk("rst_lc_a",    int'(a_lc), 0);
        chk("rst_alive_b", int'(b_alive), 15);
        chk("rst_score_b", int'(b_score), 0);
        for (int v = 0; v < 8; v++) begin
            DrawX = 10'(rt[v].x); DrawY = 10'(rt[v].y);
            cycle();
            chk($sformatf("rend%0d_dots", v), int'(a_is_dots), rt[v].dots);
            chk($sformatf("rend%0d_num", v),  int'(a_num), rt[v].num);
            chk($sformatf("rend%0d_bits", v), int'(a_is_dot), rt[v].bits);
        end

        // 2: single eat, one-cycle eat_pulse, no double count
        set_player(100, 100, 8);
        tick_edge();
        chk("eat1_alive_a", int'(a_alive), 14);
        chk("eat1_score_a", int'(a_score), 10);
        chk("eat1_pulse_a", int'(a_eat), 1);
        chk("eat1_score_b", int'(b_score), 10);
        cycle();
        chk("eat1_pulse_off", int'(a_eat), 0);
        tick_edge(); cycle();
        chk("eat1_again_score", int'(a_score), 10);

        // 3: two overlapping dots eaten together
        set_player(700, 400, 8);
        set_dot(1, 104, 100);
        do_reset();
        DrawX = 10'd102; DrawY = 10'd100;
        cycle();
        chk("ovl_num", int'(a_num), 0);
        chk("ovl_bits", int'(a_is_dot), 3);
        set_player(102, 100, 8);
        tick_edge();
        chk("two_alive_a", int'(a_alive), 12);
        chk("two_score_a", int'(a_score), 20);
        chk("two_score_b", int'(b_score), 20);
        cycle();

        // 4: respawn timing and kill on the expiry tick
        set_player(700, 400, 8);
        set_dot(1, 200, 100);
        do_reset();
        set_player(300, 100, 0);
        tick_edge();
        chk("rsp_eat_b", int'(b_alive), 11);
        set_player(700, 400, 8);
        cycle();
        for (int j = 1; j <= 3; j++) begin
            tick_edge(); cycle();
            chk($sformatf("rsp_t%0d_b", j), int'(b_alive[2]), (j == 3) ? 1 : 0);
        end
        chk("rsp_none_a", int'(a_alive[2]), 0);
        set_player(300, 100, 0);
        tick_edge();
        set_player(700, 400, 8);
        cycle();
        tick_edge(); cycle();
        tick_edge(); cycle();
        kill = 4'b0100;
        tick_edge();
        kill = '0;
        chk("rsp_kill_b", int'(b_alive[2]), 0);
        cycle();
        for (int j = 0; j < 3; j++) begin tick_edge(); cycle(); end
        chk("rsp_reload_b", int'(b_alive[2]), 1);

        // 5: level clear, frozen wait, refill
        do_reset();
        kill = 4'b0111;
        cycle();
        kill = '0;
        chk("lc_kill_alive", int'(a_alive), 8);
        chk("lc_kill_score", int'(a_score), 0);
        chk("lc_kill_lc", int'(a_lc), 0);
        set_player(400, 100, 8);
        tick_edge();
        chk("lc_pulse_a", int'(a_lc), 1);
        chk("lc_alive_a", int'(a_alive), 0);
        chk("lc_score_a", int'(a_score), 10);
        chk("lc_pulse_b", int'(b_lc), 1);
        cycle();
        chk("lc_pulse_off", int'(a_lc), 0);
        set_player(100, 100, 8);
        tick_edge(); cycle();
        chk("wait_alive", int'(a_alive), 0);
        chk("wait_score", int'(a_score), 10);
        tick_edge();
        chk("refill_a", int'(a_alive), 15);
        chk("refill_b", int'(b_alive), 15);
        chk("refill_score", int'(a_score), 10);
        cycle();
        tick_edge();
        chk("post_refill_eat", int'(a_score), 20);
        cycle();

        // 6: score saturation, reset during clear wait
        set_player(700, 400, 8);
        do_reset();
        for (int j = 0; j < 4; j++) begin
            set_player(100 + 100 * j, 100, 8);
            tick_edge();
            chk($sformatf("sat%0d_b", j), int'(b_score), (10 * (j + 1) > 31) ? 31 : 10 * (j + 1));
            chk($sformatf("sat%0d_a", j), int'(a_score), 10 * (j + 1));
            cycle();
        end
        set_player(700, 400, 8);
        tick_edge(); cycle();
        chk("rw_wait_alive", int'(a_alive), 0);
        Reset = 1'b1; cycle(); Reset = 1'b0;
        chk("rw_alive", int'(a_alive), 15);
        chk("rw_score_a", int'(a_score), 0);
        chk("rw_score_b", int'(b_score), 0);
        cycle();
        chk("rw_alive_after", int'(a_alive), 15);

        // Randomised phase against the model
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) begin
                for (int i = 0; i < 4; i++) set_dot(i, $urandom_range(0, 1023), $urandom_range(0, 1023));
                set_dot(0, 1, $urandom_range(0, 1023));
            end
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 7) == 0) begin
                int j;
                j = $urandom_range(0, 3);
                if ($urandom_range(0, 5) == 0)
                    set_player(1023, doty(j), $urandom_range(0, 12));
                else
                    set_player(clamp10(dotx(j) + $urandom_range(0, 24) - 12),
                               clamp10(doty(j) + $urandom_range(0, 24) - 12), $urandom_range(0, 12));
            end
            kill = ($urandom_range(0, 31) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
            begin
                int j;
                j = $urandom_range(0, 3);
                DrawX = 10'(clamp10(dotx(j) + $urandom_range(0, 8) - 4));
                DrawY = 10'(clamp10(doty(j) + $urandom_range(0, 8) - 4));
            end
            Reset = ($urandom_range(0, 699) == 0);
            cycle();
        end
        Reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
